// File: rtl/window_gen.sv
// ---------------------------------------------------------------------------
// window_gen
//
// Builds a 3x3 sliding pixel window for three image channels, which are
// processed in lockstep. Pixels arrive in raster order. Each channel keeps
// two line buffers (previous row and the row before it) and a 3x3 register
// window. A window is emitted only when it lies entirely inside the frame,
// so there is no edge padding. A frame yields (WIDTH-2)*(HEIGHT-2) windows.
//
// Parameters
//   WIDTH   image width in pixels (3..256)
//   HEIGHT  image height in rows  (3..256)
//
// Ports
//   i_clk                  clock; all state updates on the rising edge
//   i_rstn                 synchronous active-low reset
//   i_start                frame start request, sampled only in IDLE
//   i_valid                pixel strobe; a pixel is accepted per cycle in RUN
//   i_data0..2     [9:0]   channel 0/1/2 pixel, unsigned
//   o_busData0..2  [89:0]  3x3 window; element k=r*3+c sits at [10k+9:10k],
//                          r=0 is the top (oldest) row, c=0 the left column
//   o_valid                one-cycle strobe: a new window is on o_busData0..2
//   o_busy                 high while a frame is in progress (RUN or DONE)
//   o_done                 one-cycle pulse after the last pixel of the frame
// ---------------------------------------------------------------------------
module window_gen #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [9:0]  i_data0,
  input  logic [9:0]  i_data1,
  input  logic [9:0]  i_data2,
  output logic [89:0] o_busData0,
  output logic [89:0] o_busData1,
  output logic [89:0] o_busData2,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int NCH = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic accept;
  logic last_px;
  logic emit;

  logic [9:0]  pix      [NCH];
  logic [9:0]  lb1      [NCH][WIDTH];  // row-1 at each column
  logic [9:0]  lb2      [NCH][WIDTH];  // row-2 at each column
  logic [9:0]  win      [NCH][3][3];   // [channel][row][column]
  logic [9:0]  win_nxt  [NCH][3][3];
  logic [89:0] bus_nxt  [NCH];
  logic [89:0] bus_q    [NCH];

  assign pix[0] = i_data0;
  assign pix[1] = i_data1;
  assign pix[2] = i_data2;

  assign accept  = (state == S_RUN) && i_valid;
  assign last_px = accept && (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
  // Only windows fully inside the frame are emitted.
  assign emit    = accept && (row >= RW'(2)) && (col >= CW'(2));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (i_start) state_nxt = S_RUN;
      S_RUN:   if (last_px) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the registered state
  always_comb begin
    o_busy = (state != S_IDLE);
    o_done = (state == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Raster position counters
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      col <= '0;
      row <= '0;
    end else if ((state == S_IDLE) && i_start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(WIDTH - 1)) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next window: shift one column left, new right column is
  // {row-2, row-1, incoming pixel} read at the current column.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      for (int r = 0; r < 3; r++) begin
        win_nxt[ch][r][0] = win[ch][r][1];
        win_nxt[ch][r][1] = win[ch][r][2];
      end
      win_nxt[ch][0][2] = lb2[ch][col];
      win_nxt[ch][1][2] = lb1[ch][col];
      win_nxt[ch][2][2] = pix[ch];
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      bus_nxt[ch] = '0;
      for (int k = 0; k < 9; k++) begin
        bus_nxt[ch][10*k +: 10] = win_nxt[ch][k / 3][k % 3];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers and window registers. Read and write share the current
  // column address: the old row-1 value moves down to row-2 and the incoming
  // pixel becomes the new row-1 entry.
  // -------------------------------------------------------------------------
  // NOTE: storage arrays carry no reset; stale contents are never emitted
  // because a window needs two full rows plus three pixels of the new frame.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int ch = 0; ch < NCH; ch++) begin
        lb2[ch][col] <= lb1[ch][col];
        lb1[ch][col] <= pix[ch];
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            win[ch][r][c] <= win_nxt[ch][r][c];
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs: the window appears the cycle after its accept and
  // holds until the next emitted window.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        bus_q[ch] <= '0;
      end
    end else begin
      o_valid <= emit;
      if (emit) begin
        for (int ch = 0; ch < NCH; ch++) begin
          bus_q[ch] <= bus_nxt[ch];
        end
      end
    end
  end

  assign o_busData0 = bus_q[0];
  assign o_busData1 = bus_q[1];
  assign o_busData2 = bus_q[2];

endmodule

// File: tb/tb_window_gen.sv
// ---------------------------------------------------------------------------
// tb_window_gen
//
// Directed bench for window_gen at WIDTH=4, HEIGHT=4. Channel pixels are
// ch0 = p, ch1 = 100+p, ch2 = 200+p with p = row*4+col. The expected window
// at pixel (R,C) holds pixels (R-2+r)*4 + (C-2+c) at element k=r*3+c.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        valid;
  logic [9:0]  d0, d1, d2;
  logic [89:0] bus0, bus1, bus2;
  logic        o_valid, o_busy, o_done;

  int n_assert = 0;
  int n_fail   = 0;
  int vcount   = 0;

  logic [89:0] exp_bus [3];

  window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_valid    (valid),
    .i_data0    (d0),
    .i_data1    (d1),
    .i_data2    (d2),
    .o_busData0 (bus0),
    .o_busData1 (bus1),
    .o_busData2 (bus2),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts window strobes as seen on the DUT output.
  always @(negedge clk) if (o_valid) vcount++;

  task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [89:0] exp_win(input int off, input int r0, input int c0);
    logic [89:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[10*k +: 10] = 10'(off + (r0 - 2 + k / 3) * W + (c0 - 2 + k % 3));
    end
    return w;
  endfunction

  task automatic check_bus(input string tag);
    check({tag, ".bus0"}, bus0, exp_bus[0]);
    check({tag, ".bus1"}, bus1, exp_bus[1]);
    check({tag, ".bus2"}, bus2, exp_bus[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle inside a frame: nothing may be emitted, buses hold.
  task automatic gap_cycle(input string tag);
    valid = 1'b0;
    tick();
    check({tag, ".valid"}, o_valid, 1'b0);
    check({tag, ".done"},  o_done,  1'b0);
    check_bus(tag);
  endtask

  task automatic do_reset(input int cycles);
    rstn  = 1'b0;
    valid = 1'b0;
    start = 1'b0;
    repeat (cycles) tick();
    rstn = 1'b1;
    for (int ch = 0; ch < 3; ch++) exp_bus[ch] = '0;
    check("rst.valid", o_valid, 1'b0);
    check("rst.busy",  o_busy,  1'b0);
    check("rst.done",  o_done,  1'b0);
    check_bus("rst");
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start.busy",  o_busy,  1'b1);
    check("start.done",  o_done,  1'b0);
    check("start.valid", o_valid, 1'b0);
  endtask

  // Sends pixels 0..last. gap: 3 idle cycles after every 2nd pixel.
  // restart_at: pixel index during which i_start is also held high (-1 none).
  task automatic run_frame(input bit gap, input int restart_at, input int last);
    for (int p = 0; p <= last; p++) begin
      int r, c;
      bit qual;
      r = p / W;
      c = p % W;
      qual = (r >= 2) && (c >= 2);
      valid = 1'b1;
      start = (p == restart_at);
      d0 = 10'(p);
      d1 = 10'(100 + p);
      d2 = 10'(200 + p);
      tick();
      valid = 1'b0;
      start = 1'b0;
      if (qual) begin
        exp_bus[0] = exp_win(0,   r, c);
        exp_bus[1] = exp_win(100, r, c);
        exp_bus[2] = exp_win(200, r, c);
      end
      check($sformatf("px%0d.valid", p), o_valid, qual);
      check($sformatf("px%0d.done", p),  o_done,  (p == W * H - 1));
      check($sformatf("px%0d.busy", p),  o_busy,  1'b1);
      check_bus($sformatf("px%0d", p));
      if (gap && (p % 2 == 1) && (p != W * H - 1)) begin
        repeat (3) gap_cycle($sformatf("gap%0d", p));
      end
    end
  endtask

  // Cycle after DONE: back to IDLE.
  task automatic finish_frame(input string tag);
    tick();
    check({tag, ".done"},  o_done,  1'b0);
    check({tag, ".busy"},  o_busy,  1'b0);
    check({tag, ".valid"}, o_valid, 1'b0);
    check_bus(tag);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    d0 = '0;
    d1 = '0;
    d2 = '0;

    // Reset state
    do_reset(2);

    // i_valid in IDLE is ignored
    valid = 1'b1;
    d0 = 10'd55;
    d1 = 10'd56;
    d2 = 10'd57;
    repeat (2) begin
      tick();
      check("idle_valid.valid", o_valid, 1'b0);
      check("idle_valid.busy",  o_busy,  1'b0);
      check_bus("idle_valid");
    end
    valid = 1'b0;

    // Gap-free frame
    vcount = 0;
    start_frame();
    run_frame(1'b0, -1, 2 * W + 1);
    // Pixel 10 (row 2, col 2) produces the first window.
    valid = 1'b1;
    d0 = 10'd10;
    d1 = 10'd110;
    d2 = 10'd210;
    tick();
    valid = 1'b0;
    check("first.valid", o_valid, 1'b1);
    check("first.bus0", bus0,
          {10'd10, 10'd9, 10'd8, 10'd6, 10'd5, 10'd4, 10'd2, 10'd1, 10'd0});
    check("first.bus1.k8", {80'd0, bus1[89:80]}, 90'd110);
    check("first.bus2.k8", {80'd0, bus2[89:80]}, 90'd210);
    check("first.bus1.k0", {80'd0, bus1[9:0]},   90'd100);
    check("first.bus2.k4", {80'd0, bus2[49:40]}, 90'd205);
    exp_bus[0] = exp_win(0,   2, 2);
    exp_bus[1] = exp_win(100, 2, 2);
    exp_bus[2] = exp_win(200, 2, 2);
    check_bus("first");
    // Remaining pixels 11..15
    for (int p = 11; p < W * H; p++) begin
      int r, c;
      bit qual;
      r = p / W;
      c = p % W;
      qual = (r >= 2) && (c >= 2);
      valid = 1'b1;
      d0 = 10'(p);
      d1 = 10'(100 + p);
      d2 = 10'(200 + p);
      tick();
      valid = 1'b0;
      if (qual) begin
        exp_bus[0] = exp_win(0,   r, c);
        exp_bus[1] = exp_win(100, r, c);
        exp_bus[2] = exp_win(200, r, c);
      end
      check($sformatf("f1px%0d.valid", p), o_valid, qual);
      check($sformatf("f1px%0d.done", p),  o_done,  (p == W * H - 1));
      check_bus($sformatf("f1px%0d", p));
    end
    finish_frame("f1.end");
    check("f1.count", 90'(vcount), 90'd4);

    // Frame with gaps after every 2nd pixel
    vcount = 0;
    start_frame();
    run_frame(1'b1, -1, W * H - 1);
    finish_frame("f2.end");
    check("f2.count", 90'(vcount), 90'd4);

    // i_start mid-frame is ignored
    vcount = 0;
    start_frame();
    run_frame(1'b0, 6, W * H - 1);
    finish_frame("f3.end");
    check("f3.count", 90'(vcount), 90'd4);

    // Reset after pixel 9 abandons the frame
    vcount = 0;
    start_frame();
    run_frame(1'b0, -1, 9);
    do_reset(1);
    // Pixels offered after reset but before start are ignored
    valid = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst.valid", o_valid, 1'b0);
      check("post_rst.busy",  o_busy,  1'b0);
    end
    valid = 1'b0;
    check("post_rst.count", 90'(vcount), 90'd0);
    start_frame();
    run_frame(1'b0, -1, W * H - 1);
    finish_frame("f4.end");
    check("f4.count", 90'(vcount), 90'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
